// File: rtl/down_counter.sv
// Loadable down-counting sequencer with an IDLE/RUN/DONE control FSM.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload instead of single-shot runs.
module down_counter #(
    parameter int unsigned MAX_COUNT = 16,
    parameter int unsigned WIDTH     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             borrow_o
);

    localparam logic [WIDTH-1:0] RL_RESET = WIDTH'(MAX_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rl_q,    rl_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             zero;

    assign zero = (count_q == '0);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            rl_q    <= RL_RESET;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rl_q    <= rl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; stop outranks both the tick and the zero test
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rl_d    = rl_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_en_i) begin
                    rl_d = load_val_i;
                end
                if (start_i) begin
                    count_d = rl_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (en_i) begin
                    if (!zero) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        count_d = rl_q;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    assign count_o  = count_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign borrow_o = (state_q == RUN) && zero;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table applied through an expected-value queue.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst, en, start, stop, load_en;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       busy, done, borrow;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic       rst, en, start, stop, load_en;
        logic [7:0] load_val;
        logic [7:0] count;
        logic       busy, done, borrow;
        string      tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    down_counter #(.MAX_COUNT(16), .WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .start_i    (start),
        .stop_i     (stop),
        .load_en_i  (load_en),
        .load_val_i (load_val),
        .count_o    (count),
        .busy_o     (busy),
        .done_o     (done),
        .borrow_o   (borrow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic p,
                                input logic l, input logic [7:0] lv, input logic [7:0] c,
                                input logic b, input logic d, input logic bw, input string t);
        vec_t v;
        v.rst = r; v.en = e; v.start = s; v.stop = p; v.load_en = l; v.load_val = lv;
        v.count = c; v.busy = b; v.done = d; v.borrow = bw; v.tag = t;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector, queue its expectation, compare once the edge has produced output
    task automatic step(input vec_t v);
        vec_t e;
        rst = v.rst; en = v.en; start = v.start; stop = v.stop;
        load_en = v.load_en; load_val = v.load_val;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".count"},  int'(count),  int'(e.count));
        chk({e.tag, ".busy"},   int'(busy),   int'(e.busy));
        chk({e.tag, ".done"},   int'(done),   int'(e.done));
        chk({e.tag, ".borrow"}, int'(borrow), int'(e.borrow));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; load_en = 1'b0; load_val = 8'd0;
        @(negedge clk);

        // Reset defaults, then a run aborted by reset at count 5
        step(mk(1,0,0,0,0,0, 0,0,0,0, "reset"));
        step(mk(0,0,1,0,0,0, 15,1,0,0, "start_default"));
        for (int i = 1; i <= 10; i++)
            step(mk(0,1,0,0,0,0, 8'(15 - i),1,0,0, "tick_to_5"));
        step(mk(1,1,1,1,1,9, 0,0,0,0, "reset_midrun"));
        step(mk(0,0,1,0,0,0, 15,1,0,0, "restart_rl15"));
        step(mk(0,1,0,1,0,0, 15,0,0,0, "stop_at_15"));

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
        // Load 3 and full run
        tbl.push_back(mk(0,0,0,0,1,3, 15,0,0,0, "load3"));
        tbl.push_back(mk(0,1,1,0,0,0,  3,1,0,0, "run3_c3"));
        tbl.push_back(mk(0,1,0,0,0,0,  2,1,0,0, "run3_c2"));
        tbl.push_back(mk(0,1,0,0,0,0,  1,1,0,0, "run3_c1"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,1, "run3_c0"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,1,0, "run3_done"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,0,0, "run3_idle"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,0,0, "run3_idle2"));
        // Gated enable, rl=2
        tbl.push_back(mk(0,0,0,0,1,2,  0,0,0,0, "load2"));
        tbl.push_back(mk(0,0,1,0,0,0,  2,1,0,0, "gate_start"));
        tbl.push_back(mk(0,1,0,0,0,0,  1,1,0,0, "gate_t1"));
        tbl.push_back(mk(0,0,0,0,0,0,  1,1,0,0, "gate_h1"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,1, "gate_t2"));
        tbl.push_back(mk(0,0,0,0,0,0,  0,1,0,1, "gate_h2"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,1,0, "gate_done"));
        tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0, "gate_idle"));
        // Stop with en at count 0
        tbl.push_back(mk(0,0,1,0,0,0,  2,1,0,0, "abort_start"));
        tbl.push_back(mk(0,1,0,0,0,0,  1,1,0,0, "abort_c1"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,1, "abort_c0"));
        tbl.push_back(mk(0,1,0,1,0,0,  0,0,0,0, "abort_stop0"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,0,0, "abort_nodone"));
        // stop ignored in IDLE, start ignored in RUN
        tbl.push_back(mk(0,0,1,1,0,0,  2,1,0,0, "start_with_stop"));
        tbl.push_back(mk(0,0,0,1,0,0,  2,0,0,0, "stop_run"));
        // Simultaneous load and start uses the old reload value
        tbl.push_back(mk(0,0,0,0,1,4,  2,0,0,0, "load4"));
        tbl.push_back(mk(0,0,1,0,1,7,  4,1,0,0, "load7_start"));
        tbl.push_back(mk(0,0,1,0,1,9,  4,1,0,0, "run_ignores_ld"));
        tbl.push_back(mk(0,0,0,1,0,0,  4,0,0,0, "stop4"));
        tbl.push_back(mk(0,0,1,0,0,0,  7,1,0,0, "next_run7"));
        tbl.push_back(mk(0,0,0,1,0,0,  7,0,0,0, "stop7"));
        // Zero reload
        tbl.push_back(mk(0,0,0,0,1,0,  7,0,0,0, "load0"));
        tbl.push_back(mk(0,0,1,0,0,0,  0,1,0,1, "zero_start"));
        tbl.push_back(mk(0,0,0,0,0,0,  0,1,0,1, "zero_hold"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,1,0, "zero_done"));
        tbl.push_back(mk(0,1,1,0,1,5,  0,0,0,0, "done_ignores"));
        tbl.push_back(mk(0,0,1,0,0,0,  0,1,0,1, "restart_rl0"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,0,1,0, "rl0_done"));
        tbl.push_back(mk(0,0,0,0,0,0,  0,0,0,0, "rl0_idle"));
`else
        // Periodic reload, rl=2
        tbl.push_back(mk(0,0,0,0,1,2, 15,0,0,0, "ar_load2"));
        tbl.push_back(mk(0,1,1,0,0,0,  2,1,0,0, "ar_start"));
        tbl.push_back(mk(0,1,0,0,0,0,  1,1,0,0, "ar_c1"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,1, "ar_c0"));
        tbl.push_back(mk(0,1,0,0,0,0,  2,1,1,0, "ar_reload1"));
        tbl.push_back(mk(0,1,0,0,0,0,  1,1,0,0, "ar_c1b"));
        tbl.push_back(mk(0,0,0,0,0,0,  1,1,0,0, "ar_hold"));
        tbl.push_back(mk(0,1,0,0,0,0,  0,1,0,1, "ar_c0b"));
        tbl.push_back(mk(0,1,0,0,0,0,  2,1,1,0, "ar_reload2"));
        tbl.push_back(mk(0,1,0,1,0,0,  2,0,0,0, "ar_stop"));
        tbl.push_back(mk(0,1,0,0,0,0,  2,0,0,0, "ar_idle"));
`endif

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
